// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment codes, BCD table, anode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package stopwatch_pkg;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Active-low anode pattern with every digit dark
  localparam logic [3:0] AN_OFF = 4'hF;

  // BCD 0..9 to active-low segments; element 0 is the rightmost entry
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low one-hot anode enable for the given digit position
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_mux_bcd_to_seg7.sv
// BCD to active-low 7-segment decoder; codes 10..15 render as a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup for valid BCD, dash for anything else
  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_TABLE[i_bcd];
    end
  end

endmodule

// File: rtl/display_mux.sv
// Scans four BCD digits onto shared seg/an lines with blink, leading-zero blank, frame snapshot.
// Latency: input change shows from the first cycle of the frame after the sampling frame_tick.
// Backpressure: none; free-running scan, inputs are sampled once per frame.
module display_mux
  import stopwatch_pkg::*;
#(
  parameter int DIGIT_CYCLES = 2500,
  parameter int BLINK_FRAMES = 64
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  // A single-frame blink period still needs a 1-bit counter to exist
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);
  localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic [15:0]   r_snap_digits;
  logic [3:0]    r_snap_mask;
  logic          r_snap_lz;

  logic          w_cnt_wrap;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank;

  assign w_cnt_wrap  = (r_cnt == CNT_MAX);
  assign w_frame_end = r_active & w_cnt_wrap & (r_idx == 2'd3);
  assign frame_tick  = w_frame_end;

  // Scan counters: dwell counter per digit and digit index, idle until first release edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      r_active <= 1'b1;
      if (r_active) begin
        if (w_cnt_wrap) begin
          r_cnt <= '0;
          r_idx <= r_idx + 2'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Frame snapshot and blink phase; snapshot tracks inputs during reset so frame 1 is valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcnt        <= '0;
      r_phase       <= 1'b0;
      r_snap_digits <= digits;
      r_snap_mask   <= blink_mask;
      r_snap_lz     <= blank_lz;
    end else if (w_frame_end) begin
      r_snap_digits <= digits;
      r_snap_mask   <= blink_mask;
      r_snap_lz     <= blank_lz;
      if (r_fcnt == FR_MAX) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_digit = r_snap_digits[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  // Digit is dark when idle, in the off half of a blink, or a suppressed leading zero
  always_comb begin
    w_blank = 1'b0;
    if (!r_active) begin
      w_blank = 1'b1;
    end else if (r_phase && r_snap_mask[r_idx]) begin
      w_blank = 1'b1;
    end else if ((r_idx == 2'd3) && r_snap_lz && (r_snap_digits[15:12] == 4'd0)) begin
      w_blank = 1'b1;
    end
  end

  // Anode and segments switch together from the same registered state
  always_comb begin
    seg = w_blank ? SEG_OFF : w_seg_dec;
    an  = w_blank ? AN_OFF  : an_sel(r_idx);
  end

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux with DIGIT_CYCLES=4, BLINK_FRAMES=2.
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
// Runs a fixed number of cycles; a watchdog guards against a stalled run.
module tb_display_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  typedef struct {
    string      name;
    logic [6:0] seg;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  display_mux #(.DIGIT_CYCLES(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: output is presented every cycle; compare whenever an expectation is queued
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.tick) begin
        n_fail++;
        $display("FAIL %s: got seg=%h an=%b tick=%b, required seg=%h an=%b tick=%b",
                 e.name, seg, an, frame_tick, e.seg, e.an, e.tick);
      end
    end
  end

  // Push the expectation for the current cycle, then advance one cycle
  task automatic cyc(input string nm, input logic [6:0] s, input logic [3:0] a, input logic t);
    exp_t x;
    x.name = nm; x.seg = s; x.an = a; x.tick = t;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Assert reset with given inputs; returns positioned in cycle 1 after release
  task automatic do_reset(input string nm, input logic [15:0] d, input logic [3:0] m, input logic lz);
    rst_n = 1'b0; digits = d; blink_mask = m; blank_lz = lz;
    @(posedge clk);
    #1;
    cyc({nm, " rst0"}, 7'h7F, 4'hF, 1'b0);
    cyc({nm, " rst1"}, 7'h7F, 4'hF, 1'b0);
    rst_n = 1'b1;
    cyc({nm, " rst2"}, 7'h7F, 4'hF, 1'b0);
  endtask

  // One 16-cycle frame; bl marks digits expected dark; at cycle chg inputs switch to nd/nm/nlz
  task automatic frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] bl,
                       input int chg, input logic [15:0] nd, input logic [3:0] nmask,
                       input logic nlz);
    logic [6:0] sv[4];
    logic [3:0] av[4];
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    av[0] = 4'hE; av[1] = 4'hD; av[2] = 4'hB; av[3] = 4'h7;
    for (int n = 1; n <= 16; n++) begin
      int k;
      k = (n - 1) / 4;
      if (n == chg) begin
        digits = nd; blink_mask = nmask; blank_lz = nlz;
      end
      cyc($sformatf("%s c%0d", nm, n), bl[k] ? 7'h7F : sv[k], bl[k] ? 4'hF : av[k], n == 16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] mid_seg[4];
    logic [3:0] mid_an[4];
    rst_n = 1'b0; digits = 16'h0; blink_mask = 4'h0; blank_lz = 1'b0;

    // Scan order, then tear-free: inputs go to 0000 in cycle 6, visible only from cycle 17
    do_reset("scan", 16'h1259, 4'b0000, 1'b0);
    frame("scan f1", 7'h10, 7'h12, 7'h24, 7'h79, 4'b0000, 6, 16'h0000, 4'b0000, 1'b0);
    frame("tear f2", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 0, 16'h0, 4'h0, 1'b0);

    // Blink on digits 0/1: frames 1-2 lit, 3-4 dark, 5 lit again
    do_reset("blink", 16'h6234, 4'b0011, 1'b0);
    frame("blink f1", 7'h19, 7'h30, 7'h24, 7'h02, 4'b0000, 0, 16'h0, 4'h0, 1'b0);
    frame("blink f2", 7'h19, 7'h30, 7'h24, 7'h02, 4'b0000, 0, 16'h0, 4'h0, 1'b0);
    frame("blink f3", 7'h19, 7'h30, 7'h24, 7'h02, 4'b0011, 0, 16'h0, 4'h0, 1'b0);
    frame("blink f4", 7'h19, 7'h30, 7'h24, 7'h02, 4'b0011, 0, 16'h0, 4'h0, 1'b0);
    frame("blink f5", 7'h19, 7'h30, 7'h24, 7'h02, 4'b0000, 0, 16'h0, 4'h0, 1'b0);

    // Leading-zero blank and invalid code; blank_lz dropped mid-frame takes effect next frame
    do_reset("lz", 16'h0A45, 4'b0000, 1'b1);
    frame("lz f1", 7'h12, 7'h19, 7'h3F, 7'h40, 4'b1000, 2, 16'h0A45, 4'b0000, 1'b0);
    frame("lz f2", 7'h12, 7'h19, 7'h3F, 7'h40, 4'b0000, 0, 16'h0, 4'h0, 1'b0);

    // Reset mid-frame: low from cycle 10 for 3 cycles, new digits loaded while in reset
    mid_seg[0] = 7'h12; mid_seg[1] = 7'h19; mid_seg[2] = 7'h3F; mid_seg[3] = 7'h40;
    mid_an[0]  = 4'hE;  mid_an[1]  = 4'hD;  mid_an[2]  = 4'hB;  mid_an[3]  = 4'h7;
    for (int n = 1; n <= 10; n++) begin
      if (n == 10) rst_n = 1'b0;
      cyc($sformatf("mid f3 c%0d", n), mid_seg[(n - 1) / 4], mid_an[(n - 1) / 4], 1'b0);
    end
    digits = 16'h0987;
    cyc("mid rst c11", 7'h7F, 4'hF, 1'b0);
    cyc("mid rst c12", 7'h7F, 4'hF, 1'b0);
    rst_n = 1'b1;
    cyc("mid rst c13", 7'h7F, 4'hF, 1'b0);
    frame("mid after", 7'h78, 7'h00, 7'h10, 7'h40, 4'b0000, 0, 16'h0, 4'h0, 1'b0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux.md
# display_mux

Time-multiplexed driver for the stopwatch's 4-digit 7-segment display (MM:SS). It takes four BCD digits from the stopwatch core and scans them onto shared segment lines and per-digit anode enables. It also provides per-digit blinking for set mode, optional leading-zero blanking, and tear-free frame-synchronous sampling. It sits directly downstream of the stopwatch counter logic and drives the `seg` / `an` pins of the chip top.

## Interface
Parameters:
- `DIGIT_CYCLES`, default 2500: clock cycles each digit is lit per scan. Must be ≥ 2.
- `BLINK_FRAMES`, default 64: full 4-digit frames per blink half-period. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `digits`  in  16  `{d3,d2,d1,d0}`, 4 bits each; d3 = minutes tens, d0 = seconds ones.
- `blink_mask`  in  4  bit i=1 makes digit i blink.
- `blank_lz`  in  1  1 = blank d3 when it equals 0.
- `seg`  out  7  active-low segments, `seg[0]`=a … `seg[6]`=g.
- `an`  out  4  active-low anodes, `an[i]` selects digit i.
- `frame_tick`  out  1  high during the last cycle of each frame.

## Operation
Registers:
- `active`: 0 in reset, 1 from the first edge that samples `rst_n`=1.
- `cnt`: 0..DIGIT_CYCLES-1; width `$clog2(DIGIT_CYCLES)`.
- `idx`: 0..3.
- `fcnt`: 0..BLINK_FRAMES-1.
- `phase`: blink phase.
- `snap_digits`, `snap_mask`, `snap_lz`: the frame snapshot.

Reset:
- `cnt`, `idx`, `fcnt`, `phase`, `active` clear to 0.
- Snapshot registers load the live inputs on every reset cycle, so the first frame shows valid data.
- Outputs while `active`=0: `seg`=7'h7F, `an`=4'hF, `frame_tick`=0.

Scan:
- While `active`=1, `cnt` increments every cycle.
- When `cnt` is at DIGIT_CYCLES-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- `frame_tick` = `active` & (`cnt`==DIGIT_CYCLES-1) & (`idx`==3).

On a `frame_tick` edge:
- The snapshot reloads from the live inputs.
- `fcnt` advances. When it wraps, `phase` toggles.
- Input changes mid-frame are never displayed until the next frame.

Display of digit `idx` (combinational from registers):
- Blank if (`phase`=1 & `snap_mask[idx]`), or if (`idx`==3 & `snap_lz` & `snap_digits` d3==0).
- When blank: `an`=4'hF and `seg`=7'h7F.
- Otherwise `an` = ~(1<<`idx`) and `seg` = decode(digit).

Decode, active-low:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Codes 10–15 show a dash, 7'h3F (segment g only).

Simultaneous events:
- A frame wrap that coincides with a blink wrap applies the new snapshot and the new phase together, starting at `idx` 0.

## Timing
- Cycle n is the period after the n-th rising edge that samples `rst_n`=1.
- Frame length is 4·DIGIT_CYCLES cycles.
- Digit k is lit during cycles k·DIGIT_CYCLES+1 … (k+1)·DIGIT_CYCLES of the first frame.
- Input-to-display latency: the new value appears from the first cycle of the frame after the `frame_tick` that sampled it.
- `rst_n` low mid-frame: outputs go off in the following cycle. The scan then restarts at digit 0, cycle 1, after release.
- Anode and segment changes occur on the same edge; there are no intermediate mixed states.

## Structure
- Shared package `stopwatch_pkg` holds:
  - segment constants `SEG_OFF`=7'h7F and `SEG_DASH`=7'h3F;
  - the BCD segment table;
  - `AN_OFF`=4'hF.
- One combinational sub-module, `bcd_to_seg7` (4-bit in, 7-bit active-low out), instantiated once on the selected digit.
- Counters, snapshot and blank logic stay in `display_mux`.

## Test plan
All scenarios use DIGIT_CYCLES=4 and BLINK_FRAMES=2.
- **Scan order.** Reset with `digits`=16'h1259, mask=0, lz=0; release. Required:
  - cycles 1–4: `an`=1110, `seg`=10;
  - cycles 5–8: `an`=1101, `seg`=12;
  - cycles 9–12: `an`=1011, `seg`=24;
  - cycles 13–16: `an`=0111, `seg`=79;
  - `frame_tick` high only in cycle 16.
- **Tear-free sampling.** Change `digits` to 16'h0000 at cycle 6. Required: cycles 6–16 still show 1259; from cycle 17 `seg`=40 on every digit.
- **Blink.** `blink_mask`=4'b0011. Required:
  - frames 1–2: all digits lit;
  - frames 3–4 (cycles 33–64): `an`=1111 and `seg`=7F during the digit-0 and digit-1 slots, digits 2–3 normal;
  - frame 5 visible again.
- **Leading zero and invalid code.** `digits`=16'h0A45, `blank_lz`=1. Required:
  - digit-3 slot: `an`=1111, `seg`=7F;
  - digit-2 slot: `seg`=3F;
  - digit-0 slot: `seg`=12.
  - With `blank_lz`=0, the digit-3 slot shows `seg`=40.
- **Reset mid-frame.** `rst_n`=0 at cycle 10 for 3 cycles. Required: `an`=1111, `seg`=7F, `frame_tick`=0 throughout; after release, cycle 1 shows `an`=1110 with the current d0.
